// File: rtl/fpu_misc_pipe.sv
// FPU misc lane: sign-injection, min/max, compare and classify for S (and D when FLEN=64).
// The result is computed combinationally into stage 0 and carried by an elastic STAGES-deep valid/ready pipe.
module fpu_misc_pipe #(
    parameter int FLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic             in_fmt_i,
    input  logic [FLEN-1:0]  in_rs1_i,
    input  logic [FLEN-1:0]  in_rs2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [FLEN-1:0]  out_data_o,
    output logic             out_is_int_o,
    output logic [4:0]       out_fflags_o,
    output logic [TAG_W-1:0] out_tag_o
);
    localparam bit HAS_D = (FLEN == 64);

    typedef struct packed {
        logic        sgn;
        logic [62:0] mag;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        zero;
        logic        sub;
    } fdec_t;

    function automatic fdec_t decode(input logic [63:0] x, input logic d);
        fdec_t r;
        logic  ones, zexp, zman, quiet;
        r.sgn  = d ? x[63] : x[31];
        r.mag  = d ? x[62:0] : {32'b0, x[30:0]};
        ones   = d ? &x[62:52] : &x[30:23];
        zexp   = d ? ~|x[62:52] : ~|x[30:23];
        zman   = d ? ~|x[51:0] : ~|x[22:0];
        quiet  = d ? x[51] : x[22];
        r.inf  = ones & zman;
        r.nan  = ones & ~zman;
        r.snan = r.nan & ~quiet;
        r.zero = zexp & zman;
        r.sub  = zexp & ~zman;
        return r;
    endfunction

    logic        is_d;
    logic [63:0] a, b, canon, res;
    fdec_t       da, db;
    logic        lt_mm, lt, eq, fp_res, nv, is_int, new_sgn, norm;
    logic        unused_db;

    assign is_d      = HAS_D ? in_fmt_i : 1'b0;
    assign unused_db = db.inf ^ db.sub;

    always_comb begin
        a = 64'(in_rs1_i);
        b = 64'(in_rs2_i);
        // Improperly boxed single operands read as the canonical NaN
        if (!is_d) begin
            a = (HAS_D && a[63:32] != 32'hFFFF_FFFF) ? 64'h7FC0_0000 : {32'b0, a[31:0]};
            b = (HAS_D && b[63:32] != 32'hFFFF_FFFF) ? 64'h7FC0_0000 : {32'b0, b[31:0]};
        end
        da      = decode(a, is_d);
        db      = decode(b, is_d);
        canon   = is_d ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
        lt_mm   = (da.sgn != db.sgn) ? da.sgn
                : (da.sgn ? (da.mag > db.mag) : (da.mag < db.mag));
        lt      = lt_mm & ~(da.zero & db.zero);
        eq      = ((da.sgn == db.sgn) && (da.mag == db.mag)) || (da.zero && db.zero);
        norm    = ~(da.inf | da.nan | da.zero | da.sub);
        new_sgn = db.sgn;
        res     = '0;
        fp_res  = 1'b0;
        nv      = 1'b0;
        is_int  = 1'b0;
        case (in_op_i)
            4'd0, 4'd1, 4'd2: begin
                fp_res  = 1'b1;
                new_sgn = (in_op_i == 4'd0) ? db.sgn
                        : (in_op_i == 4'd1) ? ~db.sgn : (da.sgn ^ db.sgn);
                res     = is_d ? {new_sgn, a[62:0]} : {32'b0, new_sgn, a[30:0]};
            end
            4'd3, 4'd4: begin
                fp_res = 1'b1;
                nv     = da.snan | db.snan;
                if (da.nan && db.nan) res = canon;
                else if (da.nan)      res = b;
                else if (db.nan)      res = a;
                else                  res = (lt_mm ^ (in_op_i == 4'd4)) ? a : b;
            end
            4'd5: begin
                is_int = 1'b1;
                nv     = da.snan | db.snan;
                res    = 64'(~da.nan & ~db.nan & eq);
            end
            4'd6: begin
                is_int = 1'b1;
                nv     = da.nan | db.nan;
                res    = 64'(~da.nan & ~db.nan & lt);
            end
            4'd7: begin
                is_int = 1'b1;
                nv     = da.nan | db.nan;
                res    = 64'(~da.nan & ~db.nan & (lt | eq));
            end
            4'd8: begin
                is_int    = 1'b1;
                res[9:0]  = {da.nan & ~da.snan, da.snan,
                             ~da.sgn & da.inf, ~da.sgn & norm, ~da.sgn & da.sub, ~da.sgn & da.zero,
                             da.sgn & da.zero, da.sgn & da.sub, da.sgn & norm, da.sgn & da.inf};
            end
            default: nv = 1'b1;
        endcase
        if (fp_res && !is_d && HAS_D) res[63:32] = 32'hFFFF_FFFF;
    end

    logic [STAGES-1:0] v_q, adv, int_q;
    logic [FLEN-1:0]   data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [4:0]        fl_q   [STAGES];
    logic              accept;

    // A stage may load if it or any stage downstream of it is empty, so bubbles collapse
    always_comb begin : adv_chain
        logic acc;
        acc = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            adv[k] = acc;
        end
    end

    assign in_ready_o = adv[0] & ~flush_i & arst_i;
    assign accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            v_q   <= '0;
            int_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
                fl_q[k]   <= '0;
            end
        end else begin
            if (adv[0]) begin
                v_q[0]    <= accept;
                data_q[0] <= res[FLEN-1:0];
                tag_q[0]  <= in_tag_i;
                fl_q[0]   <= {nv, 4'b0};
                int_q[0]  <= is_int;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k]    <= v_q[k-1];
                    data_q[k] <= data_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                    fl_q[k]   <= fl_q[k-1];
                    int_q[k]  <= int_q[k-1];
                end
            end
            if (flush_i) v_q <= '0;
        end
    end

    assign out_valid_o  = v_q[STAGES-1];
    assign out_data_o   = data_q[STAGES-1];
    assign out_tag_o    = tag_q[STAGES-1];
    assign out_fflags_o = fl_q[STAGES-1];
    assign out_is_int_o = int_q[STAGES-1];
endmodule

// File: tb/tb_fpu_misc_pipe.sv
// Bench for fpu_misc_pipe: directed vectors plus randomized traffic against a value-level reference model.
module tb_fpu_misc_pipe;
    localparam int FLEN = 64, STAGES = 2, TAG_W = 5;

    logic             clk_i = 1'b0, arst_i = 1'b1, flush_i = 1'b0;
    logic             in_valid_i = 1'b0, in_fmt_i = 1'b0, out_ready_i = 1'b1;
    logic [3:0]       in_op_i = '0;
    logic [FLEN-1:0]  in_rs1_i = '0, in_rs2_i = '0;
    logic [TAG_W-1:0] in_tag_i = '0;
    logic             in_ready_o, out_valid_o, out_is_int_o;
    logic [FLEN-1:0]  out_data_o;
    logic [4:0]       out_fflags_o;
    logic [TAG_W-1:0] out_tag_o;

    int checks = 0, errors = 0;

    fpu_misc_pipe #(.FLEN(FLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i), .in_fmt_i(in_fmt_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_tag_i(in_tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_is_int_o(out_is_int_o), .out_fflags_o(out_fflags_o), .out_tag_o(out_tag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [63:0] data; logic isint; logic [4:0] fl; logic [4:0] tag; } exp_t;
    typedef struct packed { logic [3:0] op; logic d; logic [63:0] r1, r2, data; logic isint; logic [4:0] fl; } vec_t;
    exp_t sb[$];

    function automatic logic [63:0] unbox(input logic [63:0] x, input logic d);
        if (d) return x;
        if (x[63:32] != 32'hFFFF_FFFF) return 64'h7FC0_0000;
        return {32'b0, x[31:0]};
    endfunction

    // Category number equals the FCLASS bit position
    function automatic int fclass(input logic [63:0] x, input logic d);
        longint unsigned e, m, emax;
        bit s;
        if (d) begin s = x[63]; e = longint'(x[62:52]); m = longint'(x[51:0]); emax = 2047; end
        else   begin s = x[31]; e = longint'(x[30:23]); m = longint'(x[22:0]); emax = 255;  end
        if (e == emax && m != 0) return ((m >> (d ? 51 : 22)) != 0) ? 9 : 8;
        if (e == emax) return s ? 0 : 7;
        if (e == 0 && m == 0) return s ? 3 : 4;
        if (e == 0) return s ? 2 : 5;
        return s ? 1 : 6;
    endfunction

    // Signed integer whose ordering matches the numeric ordering of non-NaN values
    function automatic longint key(input logic [63:0] x, input logic d);
        longint mag;
        mag = d ? longint'(x[62:0]) : longint'(x[30:0]);
        return (d ? x[63] : x[31]) ? -mag : mag;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic d, input logic [63:0] r1, r2,
                                   input logic [4:0] tag);
        exp_t e;
        logic [63:0] x1, x2, v;
        int c1, c2;
        bit n1, n2, sn, s1, s2, sg, less;
        longint k1, k2;
        x1 = unbox(r1, d); x2 = unbox(r2, d);
        c1 = fclass(x1, d); c2 = fclass(x2, d);
        n1 = (c1 >= 8); n2 = (c2 >= 8); sn = (c1 == 8) || (c2 == 8);
        s1 = d ? x1[63] : x1[31]; s2 = d ? x2[63] : x2[31];
        k1 = key(x1, d); k2 = key(x2, d);
        less = (k1 < k2) || (k1 == k2 && s1 && !s2);
        e.tag = tag; e.isint = (op >= 5 && op <= 8); e.fl = 5'd0; v = 64'd0;
        case (op)
            4'd0, 4'd1, 4'd2: begin
                sg = (op == 4'd0) ? s2 : (op == 4'd1) ? !s2 : (s1 ^ s2);
                v  = d ? {sg, x1[62:0]} : {32'hFFFF_FFFF, sg, x1[30:0]};
            end
            4'd3, 4'd4: begin
                if (n1 && n2) v = d ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
                else if (n1)  v = x2;
                else if (n2)  v = x1;
                else          v = ((op == 4'd3) == less) ? x1 : x2;
                if (!d) v[63:32] = 32'hFFFF_FFFF;
                e.fl = sn ? 5'h10 : 5'h00;
            end
            4'd5: begin v = (!n1 && !n2 && k1 == k2) ? 64'd1 : 64'd0; e.fl = sn ? 5'h10 : 5'h00; end
            4'd6: begin v = (!n1 && !n2 && k1 <  k2) ? 64'd1 : 64'd0; e.fl = (n1 || n2) ? 5'h10 : 5'h00; end
            4'd7: begin v = (!n1 && !n2 && k1 <= k2) ? 64'd1 : 64'd0; e.fl = (n1 || n2) ? 5'h10 : 5'h00; end
            4'd8: v = 64'd1 << c1;
            default: e.fl = 5'h10;
        endcase
        e.data = v;
        return e;
    endfunction

    function automatic logic [63:0] pick(input logic d);
        logic [63:0] x;
        logic [31:0] s;
        int sel;
        sel = $urandom_range(0, 12);
        if (d) begin
            case (sel)
                0: x = 64'h0;                   1: x = 64'h8000_0000_0000_0000;
                2: x = 64'h3FF0_0000_0000_0000; 3: x = 64'hBFF0_0000_0000_0000;
                4: x = 64'h7FF0_0000_0000_0000; 5: x = 64'hFFF0_0000_0000_0000;
                6: x = 64'h7FF8_0000_0000_0000; 7: x = 64'h7FF4_0000_0000_0000;
                8: x = 64'h1;                   9: x = 64'h8008_0000_0000_0000;
                10: x = 64'h4000_0000_0000_0000; 11: x = 64'hC000_0000_0000_0000;
                default: x = {$urandom, $urandom};
            endcase
        end else begin
            case (sel)
                0: s = 32'h0;         1: s = 32'h8000_0000; 2: s = 32'h3F80_0000;  3: s = 32'hBF80_0000;
                4: s = 32'h7F80_0000; 5: s = 32'hFF80_0000; 6: s = 32'h7FC0_0000;  7: s = 32'h7FA0_0000;
                8: s = 32'h1;         9: s = 32'h8040_0000; 10: s = 32'h4000_0000; 11: s = 32'hC000_0000;
                default: s = $urandom;
            endcase
            x = {32'hFFFF_FFFF, s};
            if ($urandom_range(0, 9) == 0) x[63:32] = $urandom;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one op into an empty pipe with out_ready_i=1; report cycles until out_valid_o and the result
    task automatic run_one(input logic [3:0] op, input logic d, input logic [63:0] r1, r2, input logic [4:0] tag,
                           output int cyc, output logic [63:0] dat, output logic ii,
                           output logic [4:0] fl, output logic [4:0] tg);
        in_valid_i = 1'b1; in_op_i = op; in_fmt_i = d; in_rs1_i = r1; in_rs2_i = r2; in_tag_i = tag;
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        cyc = 1;
        while (!out_valid_o && cyc < 20) begin tick(); cyc++; end
        dat = out_data_o; ii = out_is_int_o; fl = out_fflags_o; tg = out_tag_o;
        tick();
    endtask

    task automatic test_reset();
        #2 arst_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_tag_o !== '0 || out_fflags_o !== '0 ||
            out_is_int_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h f=%h i=%b rdy=%b, expected all 0",
                     out_valid_o, out_data_o, out_tag_o, out_fflags_o, out_is_int_o, in_ready_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) arst_i = 1'b1;
        tick();
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_directed();
        vec_t vt [19];
        int cyc;
        logic [63:0] dat;
        logic ii;
        logic [4:0] fl, tg;
        vt[0]  = '{4'd3, 1'b0, 64'hFFFFFFFF_BF800000, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_BF800000, 1'b0, 5'h00};
        vt[1]  = '{4'd6, 1'b1, 64'h7FF4000000000000, 64'h0, 64'h0, 1'b1, 5'h10};
        vt[2]  = '{4'd5, 1'b1, 64'h7FF4000000000000, 64'h0, 64'h0, 1'b1, 5'h10};
        vt[3]  = '{4'd5, 1'b1, 64'h7FF8000000000000, 64'h0, 64'h0, 1'b1, 5'h00};
        vt[4]  = '{4'd8, 1'b0, 64'h00000000_3F800000, 64'h00000000_3F800000, 64'h200, 1'b1, 5'h00};
        vt[5]  = '{4'd1, 1'b0, 64'h00000000_3F800000, 64'h00000000_3F800000, 64'hFFFFFFFF_FFC00000, 1'b0, 5'h00};
        vt[6]  = '{4'd12, 1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0, 1'b0, 5'h10};
        vt[7]  = '{4'd4, 1'b0, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 1'b0, 5'h00};
        vt[8]  = '{4'd3, 1'b0, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_80000000, 1'b0, 5'h00};
        vt[9]  = '{4'd7, 1'b1, 64'h8000000000000000, 64'h0, 64'h1, 1'b1, 5'h00};
        vt[10] = '{4'd6, 1'b1, 64'h8000000000000000, 64'h0, 64'h0, 1'b1, 5'h00};
        vt[11] = '{4'd3, 1'b1, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 5'h00};
        vt[12] = '{4'd4, 1'b1, 64'h7FF4000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000, 1'b0, 5'h10};
        vt[13] = '{4'd2, 1'b1, 64'hBFF0000000000000, 64'hBFF0000000000000, 64'h3FF0000000000000, 1'b0, 5'h00};
        vt[14] = '{4'd0, 1'b0, 64'hFFFFFFFF_7FC12345, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFC12345, 1'b0, 5'h00};
        vt[15] = '{4'd8, 1'b1, 64'hFFF0000000000000, 64'h0, 64'h1, 1'b1, 5'h00};
        vt[16] = '{4'd8, 1'b0, 64'hFFFFFFFF_00000001, 64'h0, 64'h20, 1'b1, 5'h00};
        vt[17] = '{4'd6, 1'b1, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'h1, 1'b1, 5'h00};
        vt[18] = '{4'd6, 1'b0, 64'hFFFFFFFF_C0000000, 64'hFFFFFFFF_BF800000, 64'h1, 1'b1, 5'h00};
        for (int i = 0; i < 19; i++) begin
            run_one(vt[i].op, vt[i].d, vt[i].r1, vt[i].r2, 5'(i + 3), cyc, dat, ii, fl, tg);
            checks++;
            if (cyc != STAGES || dat !== vt[i].data || ii !== vt[i].isint || fl !== vt[i].fl || tg !== 5'(i + 3)) begin
                errors++;
                $display("FAIL directed[%0d]: got lat=%0d d=%h int=%b fl=%h tag=%0d, expected lat=%0d d=%h int=%b fl=%h tag=%0d",
                         i, cyc, dat, ii, fl, tg, STAGES, vt[i].data, vt[i].isint, vt[i].fl, i + 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t ex [4];
        logic [63:0] r1 [4];
        int nacc, nout, first, last;
        r1[0] = 64'h3FF0_0000_0000_0000; r1[1] = 64'hFFFFFFFF_40400000;
        r1[2] = 64'hC000_0000_0000_0000; r1[3] = 64'hFFFFFFFF_00000001;
        for (int i = 0; i < 4; i++)
            ex[i] = model(4'(i * 2), 1'(i % 2 == 0 ? 1 : 0), r1[i], 64'hBFF0_0000_0000_0000, 5'(10 + i));
        nacc = 0; nout = 0; first = -1; last = -1;
        for (int c = 0; c < 20 && nout < 4; c++) begin
            out_ready_i = (c >= 5);
            in_valid_i  = (nacc < 4);
            if (nacc < 4) begin
                in_op_i = 4'(nacc * 2); in_fmt_i = 1'(nacc % 2 == 0 ? 1 : 0);
                in_rs1_i = r1[nacc]; in_rs2_i = 64'hBFF0_0000_0000_0000; in_tag_i = 5'(10 + nacc);
            end
            @(negedge clk_i);
            if (c == 2) begin
                checks++;
                if (nacc != 2) begin errors++; $display("FAIL b2b_accepted: got %0d, expected 2", nacc); end
            end
            if (c >= 2 && c < 5) begin
                checks++;
                if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || out_data_o !== ex[0].data || out_tag_o !== ex[0].tag) begin
                    errors++;
                    $display("FAIL b2b_stall c%0d: got rdy=%b v=%b d=%h t=%0d, expected rdy=0 v=1 d=%h t=%0d",
                             c, in_ready_o, out_valid_o, out_data_o, out_tag_o, ex[0].data, ex[0].tag);
                end
            end
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (out_data_o !== ex[nout].data || out_tag_o !== ex[nout].tag ||
                    out_fflags_o !== ex[nout].fl || out_is_int_o !== ex[nout].isint) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got d=%h t=%0d fl=%h, expected d=%h t=%0d fl=%h",
                             nout, out_data_o, out_tag_o, out_fflags_o, ex[nout].data, ex[nout].tag, ex[nout].fl);
                end
                if (first < 0) first = c;
                last = c;
                nout++;
            end
            if (in_valid_i && in_ready_o) nacc++;
            tick();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        checks++;
        if (nout != 4 || last - first != 3) begin
            errors++;
            $display("FAIL b2b_drain: got %0d results over %0d cycles, expected 4 over 3", nout, last - first);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b1; in_op_i = 4'd0; in_fmt_i = 1'b1;
        in_rs1_i = 64'h3FF0_0000_0000_0000; in_rs2_i = 64'h8000_0000_0000_0000;
        for (int c = 0; c < 3; c++) begin
            in_valid_i = 1'b1; in_tag_i = 5'(20 + c);
            flush_i = (c == 2);
            if (c == 2) begin
                @(negedge clk_i);
                checks++;
                if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, expected 0", in_ready_o); end
            end
            tick();
        end
        flush_i = 1'b0; in_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_killed c%0d: got valid=%b, expected 0", c, out_valid_o); end
            tick();
        end
    endtask

    task automatic test_random(input int n);
        exp_t e;
        logic [63:0] r1, r2, pdat;
        logic d, stall, pint;
        logic [3:0] op;
        logic [4:0] tag, ptag, pfl;
        stall = 1'b0; pdat = '0; ptag = '0; pfl = '0; pint = 1'b0;
        sb.delete();
        for (int c = 0; c < n + 10; c++) begin
            d  = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            r1 = pick(d);
            r2 = ($urandom_range(0, 4) == 0) ? r1 : pick(d);
            tag = 5'($urandom);
            in_op_i = op; in_fmt_i = d; in_rs1_i = r1; in_rs2_i = r2; in_tag_i = tag;
            if (c < n) begin
                in_valid_i  = ($urandom_range(0, 3) != 0);
                out_ready_i = ($urandom_range(0, 3) != 0);
                flush_i     = ($urandom_range(0, 39) == 0);
            end else begin
                in_valid_i = 1'b0; out_ready_i = 1'b1; flush_i = 1'b0;
            end
            @(negedge clk_i);
            if (stall) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== pdat || out_tag_o !== ptag ||
                    out_fflags_o !== pfl || out_is_int_o !== pint) begin
                    errors++;
                    $display("FAIL rand_hold c%0d: got v=%b d=%h t=%0d, expected v=1 d=%h t=%0d",
                             c, out_valid_o, out_data_o, out_tag_o, pdat, ptag);
                end
            end
            stall = out_valid_o && !out_ready_i && !flush_i;
            pdat = out_data_o; ptag = out_tag_o; pfl = out_fflags_o; pint = out_is_int_o;
            if (flush_i) sb.delete();
            else begin
                if (out_valid_o && out_ready_i) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rand_spurious c%0d: got d=%h t=%0d, expected no result", c, out_data_o, out_tag_o);
                    end else begin
                        e = sb.pop_front();
                        if (out_data_o !== e.data || out_is_int_o !== e.isint || out_fflags_o !== e.fl || out_tag_o !== e.tag) begin
                            errors++;
                            $display("FAIL rand_result c%0d: got d=%h int=%b fl=%h t=%0d, expected d=%h int=%b fl=%h t=%0d",
                                     c, out_data_o, out_is_int_o, out_fflags_o, out_tag_o, e.data, e.isint, e.fl, e.tag);
                        end
                    end
                end
                if (in_valid_i && in_ready_o) sb.push_back(model(op, d, r1, r2, tag));
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d outstanding, expected 0", sb.size()); end
    endtask

    task automatic test_reset_midstream();
        int cyc;
        logic [63:0] dat;
        logic ii;
        logic [4:0] fl, tg;
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_op_i = 4'd0; in_fmt_i = 1'b1;
        in_rs1_i = 64'h3FF0_0000_0000_0000; in_rs2_i = 64'hBFF0_0000_0000_0000; in_tag_i = 5'd7;
        repeat (3) tick();
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 64'hBFF0_0000_0000_0000) begin
            errors++;
            $display("FAIL rst_mid_pre: got v=%b d=%h, expected v=1 d=bff0000000000000", out_valid_o, out_data_o);
        end
        #2 arst_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_tag_o !== '0 || out_fflags_o !== '0 ||
            out_is_int_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v=%b d=%h t=%h f=%h i=%b rdy=%b, expected all 0",
                     out_valid_o, out_data_o, out_tag_o, out_fflags_o, out_is_int_o, in_ready_o);
        end
        @(negedge clk_i) arst_i = 1'b1;
        tick();
        run_one(4'd4, 1'b1, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd9, cyc, dat, ii, fl, tg);
        checks++;
        if (cyc != STAGES || dat !== 64'h4000_0000_0000_0000 || tg !== 5'd9 || fl !== 5'h00) begin
            errors++;
            $display("FAIL rst_mid_after: got lat=%0d d=%h t=%0d fl=%h, expected lat=%0d d=4000000000000000 t=9 fl=00",
                     cyc, dat, tg, fl, STAGES);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random(600);
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
